// File: rtl/brq_mem_arbiter.sv
// Single-port memory arbiter for Buraq-mini: shares one synchronous-read memory between fetch and load/store.
// Optional fetch starvation guard is built when BRQ_ARB_STARVE_GUARD_EN is defined.
module brq_mem_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 15,
    parameter int StarveLimit = 4
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 inst_req,
    input  logic [AddrWidth-1:0] inst_addr,
    output logic                 inst_gnt,
    output logic                 inst_rvalid,
    output logic [DataWidth-1:0] inst_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [3:0]           data_be,
    input  logic [AddrWidth-1:0] data_addr,
    input  logic [DataWidth-1:0] data_wdata,
    output logic                 data_gnt,
    output logic                 data_rvalid,
    output logic [DataWidth-1:0] data_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 arb_stall
);

    localparam logic [1:0] RSP_NONE    = 2'd0;
    localparam logic [1:0] RSP_INST    = 2'd1;
    localparam logic [1:0] RSP_DATA_RD = 2'd2;
    localparam logic [1:0] RSP_DATA_WR = 2'd3;

    if (StarveLimit < 1 || StarveLimit > 15) begin : g_starve_limit_range
        $error("brq_mem_arbiter: StarveLimit must be in 1..15");
    end

    logic [1:0]           rsp_state_reg;
    logic [1:0]           rsp_state_next;
    logic [AddrWidth-1:0] addr_hold_reg;
    logic [DataWidth-1:0] wdata_hold_reg;
    logic [DataWidth-1:0] inst_rdata_reg;
    logic [DataWidth-1:0] data_rdata_reg;
    logic                 force_inst;
    logic                 data_gnt_int;
    logic                 inst_gnt_int;

`ifdef BRQ_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    // Counts consecutive cycles where data won while fetch was waiting.
    assign force_inst = inst_req & data_req & (starve_cnt_reg == STARVE_MAX);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!inst_req || inst_gnt_int) begin
            starve_cnt_next = '0;
        end else if (data_gnt_int && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    assign force_inst = 1'b0;
`endif

    // Grants are masked while reset is asserted so no access leaks out.
    assign data_gnt_int = brq_rst & data_req & ~force_inst;
    assign inst_gnt_int = brq_rst & inst_req & ~data_gnt_int;

    assign data_gnt  = data_gnt_int;
    assign inst_gnt  = inst_gnt_int;
    assign arb_stall = inst_req & ~inst_gnt_int;

    always_comb begin
        mem_en    = data_gnt_int | inst_gnt_int;
        mem_we    = data_gnt_int & data_we;
        mem_be    = 4'h0;
        mem_addr  = addr_hold_reg;
        mem_wdata = wdata_hold_reg;
        if (data_gnt_int) begin
            mem_be    = data_be;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (inst_gnt_int) begin
            mem_be   = 4'hF;
            mem_addr = inst_addr;
        end
    end

    always_comb begin
        rsp_state_next = RSP_NONE;
        if (data_gnt_int) begin
            rsp_state_next = data_we ? RSP_DATA_WR : RSP_DATA_RD;
        end else if (inst_gnt_int) begin
            rsp_state_next = RSP_INST;
        end
    end

    // Read data is forwarded from memory in the response cycle and kept afterwards.
    assign inst_rvalid = (rsp_state_reg == RSP_INST);
    assign data_rvalid = (rsp_state_reg == RSP_DATA_RD) || (rsp_state_reg == RSP_DATA_WR);
    assign inst_rdata  = inst_rvalid ? mem_rdata : inst_rdata_reg;
    assign data_rdata  = (rsp_state_reg == RSP_DATA_RD) ? mem_rdata : data_rdata_reg;

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            rsp_state_reg  <= RSP_NONE;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            rsp_state_reg <= rsp_state_next;
            if (mem_en) begin
                addr_hold_reg  <= mem_addr;
                wdata_hold_reg <= mem_wdata;
            end
            if (rsp_state_reg == RSP_INST) begin
                inst_rdata_reg <= mem_rdata;
            end
            if (rsp_state_reg == RSP_DATA_RD) begin
                data_rdata_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Testbench for brq_mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_brq_mem_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
`ifdef BRQ_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          brq_clk;
    logic          brq_rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_we;
    logic [3:0]    data_be;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          arb_stall;

    logic          tb_wr_en;
    logic [9:0]    tb_wr_addr;
    logic [DW-1:0] tb_wr_data;
    logic [DW-1:0] mem [0:1023] = '{default: '0};
    logic [DW-1:0] ref_mem [0:1023];

    int checks   = 0;
    int failures = 0;

    brq_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveLimit(LIMIT)) dut (
        .brq_clk(brq_clk), .brq_rst(brq_rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_stall(arb_stall)
    );

    initial brq_clk = 1'b0;
    always #5 brq_clk = ~brq_clk;

    // Synchronous-read memory macro with byte-enabled writes.
    always @(posedge brq_clk) begin
        if (tb_wr_en) begin
            mem[tb_wr_addr] <= tb_wr_data;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[9:0]];
            end
        end
    end

    task automatic set_idle();
        inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    endtask

    task automatic test_reset();
        brq_rst = 1'b0;
        inst_req = 1'b1; inst_addr = 15'h0020;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 15'h0005; data_wdata = '0;
        tb_wr_en = 1'b1; tb_wr_addr = 10'h010; tb_wr_data = 32'h00500093;
        repeat (3) @(negedge brq_clk);
        tb_wr_en = 1'b0;
        #1;
        checks++; if (inst_gnt !== 1'b0) begin failures++; $display("FAIL reset_inst_gnt got %b want 0", inst_gnt); end
        checks++; if (data_gnt !== 1'b0) begin failures++; $display("FAIL reset_data_gnt got %b want 0", data_gnt); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
        checks++; if (mem_we !== 1'b0 || mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_we_be got %b/%h want 0/0", mem_we, mem_be); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_addr_wdata got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got %b/%b want 0/0", inst_rvalid, data_rvalid); end
        checks++; if (inst_rdata !== '0 || data_rdata !== '0) begin failures++; $display("FAIL reset_rdata got %h/%h want 0/0", inst_rdata, data_rdata); end
        $display("txn reset held: both requests high, outputs quiet");
        @(negedge brq_clk);
        brq_rst = 1'b1;
        #1;
        checks++; if (data_gnt !== 1'b1 || inst_gnt !== 1'b0) begin failures++; $display("FAIL release_gnt got d=%b i=%b want d=1 i=0", data_gnt, inst_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 15'h0005) begin failures++; $display("FAIL release_mem got en=%b addr=%h want 1/0005", mem_en, mem_addr); end
        $display("txn reset release: data granted first cycle");
        @(negedge brq_clk);
        set_idle();
    endtask

    task automatic test_fetch_only();
        @(negedge brq_clk);
        inst_req = 1'b1; inst_addr = 15'h0010; data_req = 1'b0;
        #1;
        checks++; if (inst_gnt !== 1'b1 || data_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got i=%b d=%b want 1/0", inst_gnt, data_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF) begin failures++; $display("FAIL fetch_cmd got en=%b we=%b be=%h want 1/0/f", mem_en, mem_we, mem_be); end
        checks++; if (mem_addr !== 15'h0010) begin failures++; $display("FAIL fetch_addr got %h want 0010", mem_addr); end
        checks++; if (arb_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall got %b want 0", arb_stall); end
        @(negedge brq_clk);
        set_idle();
        #1;
        checks++; if (inst_rvalid !== 1'b1 || data_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid got i=%b d=%b want 1/0", inst_rvalid, data_rvalid); end
        checks++; if (inst_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata got %h want 00500093", inst_rdata); end
        @(negedge brq_clk);
        #1;
        checks++; if (inst_rvalid !== 1'b0 || inst_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_hold got v=%b d=%h want 0/00500093", inst_rvalid, inst_rdata); end
        $display("txn fetch 0x0010 -> 00500093");
    endtask

    task automatic test_store_load();
        @(negedge brq_clk);
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011; data_addr = 15'h0100; data_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (data_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011) begin failures++; $display("FAIL store_cmd got g=%b we=%b be=%b want 1/1/0011", data_gnt, mem_we, mem_be); end
        checks++; if (mem_addr !== 15'h0100 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_bus got %h/%h want 0100/deadbeef", mem_addr, mem_wdata); end
        @(negedge brq_clk);
        data_we = 1'b0; data_be = 4'hF;
        #1;
        checks++; if (data_rvalid !== 1'b1 || data_rdata !== 32'h0) begin failures++; $display("FAIL store_ack got v=%b d=%h want 1/0", data_rvalid, data_rdata); end
        checks++; if (data_gnt !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL load_cmd got g=%b we=%b want 1/0", data_gnt, mem_we); end
        @(negedge brq_clk);
        set_idle();
        #1;
        checks++; if (data_rvalid !== 1'b1 || data_rdata !== 32'h0000BEEF) begin failures++; $display("FAIL load_data got v=%b d=%h want 1/0000beef", data_rvalid, data_rdata); end
        $display("txn store deadbeef be=0011 then load 0x0100 -> 0000beef");
    endtask

    task automatic test_contention();
        logic exp_inst;
        for (int k = 0; k < 10; k++) begin
            @(negedge brq_clk);
            inst_req = 1'b1; inst_addr = 15'h0020;
            data_req = 1'b1; data_we = 1'b0; data_addr = 15'h0030;
            #1;
            exp_inst = GUARD && (k % (LIMIT + 1) == LIMIT);
            checks++; if (inst_gnt !== exp_inst || data_gnt !== !exp_inst) begin failures++; $display("FAIL contention_gnt[%0d] got i=%b d=%b want i=%b", k, inst_gnt, data_gnt, exp_inst); end
            checks++; if (arb_stall !== !exp_inst) begin failures++; $display("FAIL contention_stall[%0d] got %b want %b", k, arb_stall, !exp_inst); end
            checks++; if (mem_addr !== (exp_inst ? 15'h0020 : 15'h0030)) begin failures++; $display("FAIL contention_addr[%0d] got %h", k, mem_addr); end
            $display("txn contention cycle %0d inst_gnt=%b data_gnt=%b", k, inst_gnt, data_gnt);
        end
        @(negedge brq_clk);
        set_idle();
        @(negedge brq_clk);
    endtask

    task automatic test_reset_mid();
        @(negedge brq_clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 15'h0100;
        #1;
        checks++; if (data_gnt !== 1'b1) begin failures++; $display("FAIL midrst_grant got %b want 1", data_gnt); end
        #1;
        brq_rst = 1'b0;
        #1;
        checks++; if (data_gnt !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL midrst_mask got g=%b en=%b want 0/0", data_gnt, mem_en); end
        @(negedge brq_clk);
        set_idle();
        brq_rst = 1'b1;
        #1;
        checks++; if (data_rvalid !== 1'b0 || data_rdata !== '0 || inst_rdata !== '0) begin failures++; $display("FAIL midrst_after got v=%b d=%h i=%h want 0/0/0", data_rvalid, data_rdata, inst_rdata); end
        @(negedge brq_clk);
        #1;
        checks++; if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_late got %b/%b want 0/0", data_rvalid, inst_rvalid); end
        $display("txn reset mid-load: response dropped");
    endtask

    // Reference model: arbitration rules, pending response, hold values and a golden memory.
    task automatic test_random();
        int            pend;
        int            cnt;
        logic [DW-1:0] pend_val, e_ird, e_drd, last_wdata, e_wd;
        logic [AW-1:0] last_addr, e_addr;
        logic [3:0]    e_be;
        logic          force_i, e_dg, e_ig;
        pend = 0; cnt = 0; pend_val = '0; e_ird = '0; e_drd = '0; last_wdata = '0; last_addr = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int n = 0; n < 300; n++) begin
            @(negedge brq_clk);
            inst_req   = ($urandom_range(0, 9) < 6);
            inst_addr  = 15'($urandom_range(0, 63));
            data_req   = ($urandom_range(0, 1) == 1);
            data_we    = ($urandom_range(0, 1) == 1);
            data_be    = 4'($urandom_range(0, 15));
            data_addr  = 15'($urandom_range(0, 63));
            data_wdata = $urandom;
            #1;
            force_i = GUARD && (cnt == LIMIT) && inst_req && data_req;
            e_dg = data_req && !force_i;
            e_ig = inst_req && !e_dg;
            if (pend == 1) e_ird = pend_val;
            if (pend == 2) e_drd = pend_val;
            e_be   = e_dg ? data_be : (e_ig ? 4'hF : 4'h0);
            e_addr = e_dg ? data_addr : (e_ig ? inst_addr : last_addr);
            e_wd   = e_dg ? data_wdata : last_wdata;
            checks++; if (data_gnt !== e_dg || inst_gnt !== e_ig) begin failures++; $display("FAIL rnd_gnt[%0d] got d=%b i=%b want d=%b i=%b", n, data_gnt, inst_gnt, e_dg, e_ig); end
            checks++; if (arb_stall !== (inst_req && !e_ig)) begin failures++; $display("FAIL rnd_stall[%0d] got %b", n, arb_stall); end
            checks++; if (mem_en !== (e_dg || e_ig) || mem_we !== (e_dg && data_we)) begin failures++; $display("FAIL rnd_en_we[%0d] got %b/%b", n, mem_en, mem_we); end
            checks++; if (mem_be !== e_be || mem_addr !== e_addr) begin failures++; $display("FAIL rnd_be_addr[%0d] got %h/%h want %h/%h", n, mem_be, mem_addr, e_be, e_addr); end
            if (!e_ig) begin
                checks++; if (mem_wdata !== e_wd) begin failures++; $display("FAIL rnd_wdata[%0d] got %h want %h", n, mem_wdata, e_wd); end
            end
            checks++; if (inst_rvalid !== (pend == 1) || data_rvalid !== (pend >= 2)) begin failures++; $display("FAIL rnd_rvalid[%0d] got i=%b d=%b pend=%0d", n, inst_rvalid, data_rvalid, pend); end
            checks++; if (inst_rdata !== e_ird || data_rdata !== e_drd) begin failures++; $display("FAIL rnd_rdata[%0d] got %h/%h want %h/%h", n, inst_rdata, data_rdata, e_ird, e_drd); end
            $display("txn %0d ireq=%b dreq=%b we=%b addr=%h gnt i/d=%b/%b", n, inst_req, data_req, data_we, e_addr, inst_gnt, data_gnt);
            pend_val = ref_mem[e_addr[9:0]];
            if (e_dg && data_we) begin
                for (int b = 0; b < 4; b++) if (data_be[b]) ref_mem[data_addr[9:0]][8*b +: 8] = data_wdata[8*b +: 8];
            end
            pend = e_dg ? (data_we ? 3 : 2) : (e_ig ? 1 : 0);
            if (!inst_req || e_ig) cnt = 0;
            else if (e_dg && cnt < LIMIT) cnt++;
            if (e_dg || e_ig) last_addr = e_addr;
            if (e_dg) last_wdata = data_wdata;
        end
        @(negedge brq_clk);
        set_idle();
    endtask

    initial begin
        brq_rst = 1'b0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        set_idle(); inst_addr = '0; data_be = '0; data_addr = '0; data_wdata = '0;
        test_reset();
        test_fetch_only();
        test_store_load();
        test_contention();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
